// File: rtl/motor_ramp_pwm_if.sv
// Command port of motor_ramp_pwm: one channel's target duty and direction per valid/ready transfer.
interface motor_ramp_pwm_if #(
   parameter int N_CH   = 2,
   parameter int DUTY_W = 10
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic              valid;
   logic              ready;
   logic [CH_W-1:0]   ch;
   logic [DUTY_W-1:0] duty;
   logic              dir;

   modport master (output valid, ch, duty, dir, input ready);
   modport slave  (input valid, ch, duty, dir, output ready);
endinterface

// File: rtl/motor_ramp_pwm.sv
// N-channel motor PWM driver: slew-limited duty ramping, safe reversal through zero, emergency stop.
module motor_ramp_pwm #(
   parameter int N_CH     = 2,
   parameter int DUTY_W   = 10,
   parameter int PERIOD   = 4000,
   parameter int RAMP_DIV = 1000,
   parameter int STEP     = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   estop,
   motor_ramp_pwm_if.slave        cmd,
   output logic [N_CH-1:0]        pwm,
   output logic [N_CH-1:0]        dir,
   output logic [N_CH-1:0]        busy
);
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int RMP_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int PROD_W = DUTY_W + $clog2(PERIOD + 1);
   localparam logic [DUTY_W-1:0] STEP_D = DUTY_W'(STEP);

   typedef enum logic [1:0] {IDLE, RAMP, REV} state_t;

   logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
   logic [RMP_W-1:0]  rmp_cnt_q, rmp_cnt_d;
   logic              rdy_en_q, rdy_en_d;
   logic [DUTY_W-1:0] cur_q [N_CH];
   logic [DUTY_W-1:0] cur_d [N_CH];
   logic [DUTY_W-1:0] tgt_q [N_CH];
   logic [DUTY_W-1:0] tgt_d [N_CH];
   logic [PROD_W-1:0] cmp_q [N_CH];
   logic [PROD_W-1:0] cmp_d [N_CH];
   logic [PROD_W-1:0] cmp_new [N_CH];
   state_t            state_q [N_CH];
   state_t            state_d [N_CH];
   logic [N_CH-1:0]   tdir_q, tdir_d, dir_q, dir_d, pwm_q, pwm_d;
   logic              tick, period_start, cmd_fire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_cnt_q <= '0;
         rmp_cnt_q <= '0;
         rdy_en_q  <= 1'b0;
         tdir_q    <= '0;
         dir_q     <= '0;
         pwm_q     <= '0;
         for (int i = 0; i < N_CH; i++) begin
            cur_q[i]   <= '0;
            tgt_q[i]   <= '0;
            cmp_q[i]   <= '0;
            state_q[i] <= IDLE;
         end
      end else begin
         per_cnt_q <= per_cnt_d;
         rmp_cnt_q <= rmp_cnt_d;
         rdy_en_q  <= rdy_en_d;
         tdir_q    <= tdir_d;
         dir_q     <= dir_d;
         pwm_q     <= pwm_d;
         for (int i = 0; i < N_CH; i++) begin
            cur_q[i]   <= cur_d[i];
            tgt_q[i]   <= tgt_d[i];
            cmp_q[i]   <= cmp_d[i];
            state_q[i] <= state_d[i];
         end
      end
   end

   // Ramp moves use the registered target, so a command landing on a tick only counts from the next tick.
   always_comb begin
      tick         = (rmp_cnt_q == RMP_W'(RAMP_DIV - 1));
      period_start = (per_cnt_q == '0);
      cmd_fire     = cmd.valid && rdy_en_q && !estop;
      per_cnt_d    = (per_cnt_q == CNT_W'(PERIOD - 1)) ? '0 : per_cnt_q + 1'b1;
      rmp_cnt_d    = tick ? '0 : rmp_cnt_q + 1'b1;
      rdy_en_d     = 1'b1;
      tdir_d       = tdir_q;
      dir_d        = dir_q;
      pwm_d        = pwm_q;
      for (int i = 0; i < N_CH; i++) begin
         cur_d[i]   = cur_q[i];
         tgt_d[i]   = tgt_q[i];
         cmp_d[i]   = cmp_q[i];
         cmp_new[i] = (PROD_W'(cur_q[i]) * PROD_W'(PERIOD)) >> DUTY_W;

         if (tick) begin
            unique case (state_q[i])
               RAMP: begin
                  if (tgt_q[i] > cur_q[i])
                     cur_d[i] = ((tgt_q[i] - cur_q[i]) > STEP_D) ? cur_q[i] + STEP_D : tgt_q[i];
                  else
                     cur_d[i] = ((cur_q[i] - tgt_q[i]) > STEP_D) ? cur_q[i] - STEP_D : tgt_q[i];
               end
               REV: begin
                  if (cur_q[i] > STEP_D) begin
                     cur_d[i] = cur_q[i] - STEP_D;
                  end else begin
                     cur_d[i] = '0;
                     dir_d[i] = tdir_q[i];
                  end
               end
               default: ;
            endcase
         end

         if (cmd_fire && (cmd.ch == CH_W'(i))) begin
            tgt_d[i]  = cmd.duty;
            tdir_d[i] = cmd.dir;
         end

         // Compare value only moves at the period boundary so a running pulse is never cut short or stretched.
         if (period_start) begin
            cmp_d[i] = cmp_new[i];
            pwm_d[i] = (cmp_new[i] != '0);
         end else begin
            pwm_d[i] = (PROD_W'(per_cnt_q) < cmp_q[i]);
         end

         if (dir_d[i] != dir_q[i]) begin
            cmp_d[i] = '0;
            pwm_d[i] = 1'b0;
         end

         if (estop) begin
            cur_d[i]  = '0;
            tgt_d[i]  = '0;
            tdir_d[i] = dir_q[i];
            dir_d[i]  = dir_q[i];
            cmp_d[i]  = '0;
            pwm_d[i]  = 1'b0;
         end

         if (dir_d[i] != tdir_d[i])
            state_d[i] = REV;
         else if (cur_d[i] != tgt_d[i])
            state_d[i] = RAMP;
         else
            state_d[i] = IDLE;
      end
   end

   always_comb begin
      cmd.ready = rdy_en_q && !estop;
      pwm       = pwm_q;
      dir       = dir_q;
      for (int i = 0; i < N_CH; i++)
         busy[i] = (state_q[i] != IDLE);
   end

endmodule
